// File: rtl/multitone_stream_source_if.sv
// Sample stream bus for the multitone source: signed data plus a valid/ready handshake.
interface multitone_stream_source_if #(
  parameter int OW = 24
);
  logic signed [OW-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/multitone_stream_source.sv
// Three-tone DDS stimulus source: a shared quarter-wave cosine LUT feeds three phase
// accumulators, and the summed tones are emitted on a stream bus once every DIV enabled cycles.
module multitone_stream_source #(
  parameter int            PW    = 32,
  parameter int            DW    = 20,
  parameter int            AW    = 13,
  parameter int            OW    = 24,
  parameter int            DIV   = 195,
  parameter logic [PW-1:0] FREQ0 = PW'(429496),
  parameter logic [PW-1:0] FREQ1 = PW'(42949),
  parameter logic [PW-1:0] FREQ2 = PW'(4294)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  multitone_stream_source_if.master  m,
  output logic                       overrun
);
  localparam int NT = 3;
  localparam int Q  = 2 ** (AW - 2);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam real PI = 3.14159265358979323846;
  localparam logic [NT-1:0][PW-1:0] FREQ = {FREQ2, FREQ1, FREQ0};

  // First quadrant of round((2^(DW-1)-1)*cos(2*pi*i/2^AW)), i = 0..Q; all entries are >= 0.
  function automatic logic [DW-1:0] qcos(int i);
    real r;
    r = real'(2 ** (DW - 1) - 1) * $cos(PI * real'(i) / real'(2 * Q));
    return DW'($rtoi(r + 0.5));
  endfunction

  logic [DW-1:0] qtab [Q+1];
  for (genvar i = 0; i <= Q; i++) begin : g_q
    assign qtab[i] = qcos(i);
  end

  // Strobe counter
  logic [CW-1:0] cnt;
  logic          tick;
  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     cnt <= '0;
    else if (en) cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1;
  end

  // DDS channels; the quadrant bits pick mirror (odd quadrants) and negate (middle two).
  logic [NT-1:0][DW-1:0] cosr;
  for (genvar k = 0; k < NT; k++) begin : g_ch
    logic [PW-1:0] ph;
    logic [DW-1:0] cr;
    logic [AW-1:0] a;
    logic [AW-2:0] idx;
    logic [DW-1:0] q;
    logic [DW-1:0] lut;

    assign a   = ph[PW-1 -: AW];
    assign idx = a[AW-2] ? (AW-1)'(Q) - {1'b0, a[AW-3:0]} : {1'b0, a[AW-3:0]};
    assign q   = qtab[idx];
    assign lut = (a[AW-1] ^ a[AW-2]) ? DW'(-q) : q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ph <= '0;
        cr <= '0;
      end else if (en) begin
        ph <= ph + FREQ[k];
        cr <= lut;
      end
    end

    assign cosr[k] = cr;
  end

  logic signed [OW-1:0] sum;
  always_comb begin
    sum = '0;
    for (int k = 0; k < NT; k++) sum = sum + OW'($signed(cosr[k]));
  end

  // A tick that finds the previous sample still pending drops the new one and latches overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m.data  <= '0;
      m.valid <= 1'b0;
      overrun <= 1'b0;
    end else if (tick && (!m.valid || m.ready)) begin
      m.data  <= sum;
      m.valid <= 1'b1;
    end else if (tick) begin
      overrun <= 1'b1;
    end else if (m.valid && m.ready) begin
      m.valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_multitone_stream_source.sv
// Directed bench for multitone_stream_source: default tones, all-zero tones and a Nyquist tone.
module tb_multitone_stream_source;
  localparam int  OW   = 24;
  localparam int  FULL = 1572861;
  localparam int  HALF = 524287;
  localparam real PI   = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic m_ready = 1'b1;
  logic ovf, ovf_z, ovf_h;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multitone_stream_source_if #(.OW(OW)) bus (), bus_z (), bus_h ();
  assign bus.ready   = m_ready;
  assign bus_z.ready = m_ready;
  assign bus_h.ready = m_ready;

  multitone_stream_source dut (
    .clk(clk), .rst(rst), .en(en), .m(bus), .overrun(ovf));
  multitone_stream_source #(.FREQ0(32'd0), .FREQ1(32'd0), .FREQ2(32'd0)) dut_z (
    .clk(clk), .rst(rst), .en(en), .m(bus_z), .overrun(ovf_z));
  multitone_stream_source #(.FREQ0(32'h8000_0000), .FREQ1(32'd0), .FREQ2(32'd0)) dut_h (
    .clk(clk), .rst(rst), .en(en), .m(bus_h), .overrun(ovf_h));

  // One tone's cosine for sample j, straight from the full-table definition.
  function automatic int tone(logic [31:0] f, int j);
    logic [31:0] p;
    int a;
    real r;
    p = 32'(j * 195 - 2) * f;
    a = int'(p[31:19]);
    r = 524287.0 * $cos(2.0 * PI * real'(a) / 8192.0);
    return $rtoi($floor(r + 0.5));
  endfunction

  function automatic int model(int j);
    return tone(32'd429496, j) + tone(32'd42949, j) + tone(32'd4294, j);
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; m_ready = 1'b1;
    step(2);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.valid); end
    checks++; if (bus.data !== '0) begin errors++; $display("FAIL reset_data got %0d want 0", bus.data); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b want 0", ovf); end
    rst = 1'b0;
  endtask

  task automatic test_rate();
    step(194);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rate_early got %0b want 0", bus.valid); end
    step(1);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL rate_first got %0b want 1", bus.valid); end
    checks++; if (int'(bus.data) !== model(1)) begin errors++; $display("FAIL rate_s1 got %0d want %0d", bus.data, model(1)); end
    checks++; if (int'(bus_z.data) !== FULL) begin errors++; $display("FAIL zero_s1 got %0d want %0d", bus_z.data, FULL); end
    checks++; if (int'(bus_h.data) !== HALF) begin errors++; $display("FAIL nyq_s1 got %0d want %0d", bus_h.data, HALF); end
    step(1);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rate_pulse got %0b want 0", bus.valid); end
    step(193);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rate_gap got %0b want 0", bus.valid); end
    step(1);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL rate_second got %0b want 1", bus.valid); end
    checks++; if (int'(bus.data) !== model(2)) begin errors++; $display("FAIL rate_s2 got %0d want %0d", bus.data, model(2)); end
    checks++; if (int'(bus_z.data) !== FULL) begin errors++; $display("FAIL zero_s2 got %0d want %0d", bus_z.data, FULL); end
    checks++; if (int'(bus_h.data) !== FULL) begin errors++; $display("FAIL nyq_s2 got %0d want %0d", bus_h.data, FULL); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rate_overrun got %0b want 0", ovf); end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    do_reset();
    step(195);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %0b want 1", bus.valid); end
    step(194);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_early got %0b want 0", ovf); end
    step(1);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf got %0b want 1", ovf); end
    step(10);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %0b want 1", bus.valid); end
    checks++; if (int'(bus.data) !== model(1)) begin errors++; $display("FAIL bp_frozen got %0d want %0d", bus.data, model(1)); end
    m_ready = 1'b1;
    step(1);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL bp_xfer got %0b want 0", bus.valid); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_sticky got %0b want 1", ovf); end
    step(184);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got %0b want 1", bus.valid); end
    checks++; if (int'(bus.data) !== model(3)) begin errors++; $display("FAIL bp_s3 got %0d want %0d", bus.data, model(3)); end
  endtask

  task automatic test_enable();
    m_ready = 1'b1;
    do_reset();
    step(100);
    en = 1'b0;
    step(50);
    en = 1'b1;
    step(94);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL en_early got %0b want 0", bus.valid); end
    step(1);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL en_delayed got %0b want 1", bus.valid); end
    checks++; if (int'(bus.data) !== model(1)) begin errors++; $display("FAIL en_s1 got %0d want %0d", bus.data, model(1)); end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    do_reset();
    step(395);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL rm_ovf_pre got %0b want 1", ovf); end
    rst = 1'b1;
    #2;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %0b want 0", bus.valid); end
    checks++; if (bus.data !== '0) begin errors++; $display("FAIL rm_data got %0d want 0", bus.data); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rm_ovf got %0b want 0", ovf); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready = 1'b1;
    step(194);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rm_early got %0b want 0", bus.valid); end
    step(1);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL rm_first got %0b want 1", bus.valid); end
    checks++; if (int'(bus.data) !== model(1)) begin errors++; $display("FAIL rm_s1 got %0d want %0d", bus.data, model(1)); end
  endtask

  initial begin
    test_reset();
    test_rate();
    test_backpressure();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
